dx_latch: RTL

Decode-to-execute (D/X) pipeline register for the five-stage ECE 350 core. Captures the instruction, PC and both register-file read operands from the decode stage each cycle, and presents them to execute. Its `dx_opcode` output drives the execute-stage ALU-B immediate-select decode and the other X-stage controls. It also detects load-use hazards, stalls fetch/decode and inserts bubbles, applies branch flushes, and counts inserted bubbles.

---
 rtl/isa_pkg.sv | 35 +++
 rtl/load_use_detect.sv | 68 ++++++
 rtl/dx_latch.sv | 84 ++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the five-stage core: opcodes, field positions, NOP.
package isa_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 5;

    // Field bit positions
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RD_MSB = 26;
    localparam int unsigned RD_LSB = 22;
    localparam int unsigned RS_MSB = 21;
    localparam int unsigned RS_LSB = 17;
    localparam int unsigned RT_MSB = 16;
    localparam int unsigned RT_LSB = 12;

    localparam logic [OP_W-1:0] OP_RTYPE = 5'b00000;
    localparam logic [OP_W-1:0] OP_J     = 5'b00001;
    localparam logic [OP_W-1:0] OP_BNE   = 5'b00010;
    localparam logic [OP_W-1:0] OP_JAL   = 5'b00011;
    localparam logic [OP_W-1:0] OP_JR    = 5'b00100;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'b00101;
    localparam logic [OP_W-1:0] OP_BLT   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SW    = 5'b00111;
    localparam logic [OP_W-1:0] OP_LW    = 5'b01000;
    localparam logic [OP_W-1:0] OP_SETX  = 5'b10101;
    localparam logic [OP_W-1:0] OP_BEX   = 5'b10110;

    localparam logic [INSN_W-1:0] NOP = 32'h0000_0000;

    localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;
    localparam logic [REG_W-1:0] REG_STATUS = 5'd30;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an F/D instruction that reads the
// destination of a lw currently sitting in D/X. Compiled only when
// LOAD_USE_STALL_EN is defined, since nothing else instantiates it.
`ifdef LOAD_USE_STALL_EN
module load_use_detect
    import isa_pkg::*;
(
    input  logic [INSN_W-1:0] dx_insn,
    input  logic              dx_valid,
    input  logic [INSN_W-1:0] fd_insn,
    input  logic              fd_valid,
    output logic              hazard
);

    logic [OP_W-1:0]  fd_op;
    logic [REG_W-1:0] fd_rd;
    logic [REG_W-1:0] fd_rs;
    logic [REG_W-1:0] fd_rt;
    logic [OP_W-1:0]  dx_op;
    logic [REG_W-1:0] dx_rd;
    logic             use_rs;
    logic             use_rt;
    logic             use_rd;
    logic             use_r30;
    logic             dx_is_load;
    logic             unused_bits;

    assign fd_op = fd_insn[OP_MSB:OP_LSB];
    assign fd_rd = fd_insn[RD_MSB:RD_LSB];
    assign fd_rs = fd_insn[RS_MSB:RS_LSB];
    assign fd_rt = fd_insn[RT_MSB:RT_LSB];
    assign dx_op = dx_insn[OP_MSB:OP_LSB];
    assign dx_rd = dx_insn[RD_MSB:RD_LSB];

    // Immediate / low fields never name a source register.
    assign unused_bits = ^{fd_insn[RT_LSB-1:0], dx_insn[RS_MSB:0]};

    // Which source registers the F/D instruction reads
    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        use_rd  = 1'b0;
        use_r30 = 1'b0;
        case (fd_op)
            OP_RTYPE:                begin use_rs = 1'b1; use_rt = 1'b1; end
            OP_ADDI, OP_LW:          use_rs = 1'b1;
            OP_SW, OP_BNE, OP_BLT:   begin use_rs = 1'b1; use_rd = 1'b1; end
            OP_JR:                   use_rd = 1'b1;
            OP_BEX:                  use_r30 = 1'b1;
            default:                 ;
        endcase
    end

    assign dx_is_load = dx_valid && (dx_op == OP_LW) && (dx_rd != REG_ZERO);

    // Hazard when any used source matches the in-flight load destination
    always_comb begin
        hazard = 1'b0;
        if (dx_is_load && fd_valid) begin
            hazard = (use_rs  && (fd_rs == dx_rd))      ||
                     (use_rt  && (fd_rt == dx_rd))      ||
                     (use_rd  && (fd_rd == dx_rd))      ||
                     (use_r30 && (REG_STATUS == dx_rd));
        end
    end

endmodule
`endif

// File: rtl/dx_latch.sv
// Decode-to-execute pipeline register with branch flush, multdiv hold,
// load-use bubble insertion and a saturating bubble counter.
// Macro LOAD_USE_STALL_EN enables hazard detection and bubble counting;
// without it the hazard term is 0 and load-use spacing is left to software.
module dx_latch
    import isa_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     fd_insn,
    input  logic [WIDTH-1:0]     fd_pc,
    input  logic                 fd_valid,
    input  logic [WIDTH-1:0]     rf_data_a,
    input  logic [WIDTH-1:0]     rf_data_b,
    input  logic                 flush,
    input  logic                 hold,
    output logic [WIDTH-1:0]     dx_insn,
    output logic [WIDTH-1:0]     dx_pc,
    output logic [WIDTH-1:0]     dx_a,
    output logic [WIDTH-1:0]     dx_b,
    output logic [OP_W-1:0]      dx_opcode,
    output logic                 dx_valid,
    output logic                 stall_fd,
    output logic [CNT_WIDTH-1:0] bubble_count
);

    logic hazard;

`ifdef LOAD_USE_STALL_EN
    load_use_detect u_load_use_detect (
        .dx_insn  (INSN_W'(dx_insn)),
        .dx_valid (dx_valid),
        .fd_insn  (INSN_W'(fd_insn)),
        .fd_valid (fd_valid),
        .hazard   (hazard)
    );
`else
    assign hazard = 1'b0;
`endif

    assign dx_opcode = dx_insn[OP_MSB:OP_LSB];

    // Freeze PC and F/D on a hazard or hold; a flush overrides, reset forces 0
    assign stall_fd = reset_n && !flush && (hazard || hold);

    // D/X register update: reset > flush > hold > bubble > normal load
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dx_insn      <= '0;
            dx_pc        <= '0;
            dx_a         <= '0;
            dx_b         <= '0;
            dx_valid     <= 1'b0;
            bubble_count <= '0;
        end else if (flush) begin
            dx_insn  <= WIDTH'(NOP);
            dx_pc    <= '0;
            dx_a     <= '0;
            dx_b     <= '0;
            dx_valid <= 1'b0;
        end else if (!hold) begin
            if (hazard) begin
                dx_insn  <= WIDTH'(NOP);
                dx_pc    <= '0;
                dx_a     <= '0;
                dx_b     <= '0;
                dx_valid <= 1'b0;
                if (bubble_count != '1) begin
                    bubble_count <= bubble_count + CNT_WIDTH'(1);
                end
            end else begin
                dx_insn  <= fd_insn;
                dx_pc    <= fd_pc;
                dx_a     <= rf_data_a;
                dx_b     <= rf_data_b;
                dx_valid <= fd_valid;
            end
        end
    end

endmodule
